// File: rtl/led_arbiter.sv
// led_arbiter: three-requester round-robin arbiter that lends an 8-bit LED
// bank to one requester at a time. It also drives a heartbeat pattern on
// LEDG[3] while nobody owns the bank.
//
// Request/grant protocol: req[i] is a level request. grant is registered and
// one-hot, or zero when the bank is free. An owner keeps the bank while its
// req stays high. If another requester is pending, the owner is rotated out
// after HOLD_CYCLES contiguous grant cycles. No request is remembered once
// its req level drops.
//
// Ports:
//   CLOCK_50   in   1  clock; all state updates on the rising edge
//   RESET_N    in   1  asynchronous active-low reset
//   req        in   3  level request; bit i belongs to requester i
//   data_0..2  in   8  LED pattern offered by each requester
//   grant      out  3  registered one-hot grant (zero when idle)
//   busy       out  1  |grant
//   LEDG       out  8  registered LED drive
//   dbg_state  out  1  FSM state (0 = IDLE, 1 = OWNED)
module led_arbiter #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned HEARTBEAT_DIV = 25_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [2:0] req,
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  input  logic [7:0] data_2,
  output logic [2:0] grant,
  output logic       busy,
  output logic [7:0] LEDG,
  output logic       dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  localparam logic [31:0] HOLD_MAX = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] HB_MAX   = 32'(HEARTBEAT_DIV - 1);

  state_e      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] hb_cnt_q, hb_cnt_d;
  logic        hb_q, hb_d;
  logic [7:0]  ledg_q, ledg_d;

  // Round-robin search of mask starting at from+1 (mod 3), wrapping back to
  // from last. Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [2:0] mask,
                                         input logic [1:0] from);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    idx = from;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!res[2] && mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // In OWNED, last_q is always the current owner's index.
  logic [2:0] own_mask;
  logic [2:0] others;
  logic [2:0] pick_any;
  logic [2:0] pick_oth;
  logic       own_req;

  assign own_mask = 3'b001 << last_q;
  assign others   = req & ~own_mask;
  assign pick_any = rr_pick(req, last_q);
  assign pick_oth = rr_pick(others, last_q);
  assign own_req  = |(req & own_mask);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any[2]) begin
          state_d = OWNED;
          grant_d = 3'b001 << pick_any[1:0];
          last_d  = pick_any[1:0];
          hold_d  = 32'd0;
        end
      end
      OWNED: begin
        if ((!own_req || hold_q == HOLD_MAX) && pick_oth[2]) begin
          // Hand over directly, without passing through IDLE.
          grant_d = 3'b001 << pick_oth[1:0];
          last_d  = pick_oth[1:0];
          hold_d  = 32'd0;
        end else if (!own_req) begin
          state_d = IDLE;
          grant_d = 3'b000;
          hold_d  = 32'd0;
        end else if (hold_q != HOLD_MAX) begin
          // Saturates at HOLD_MAX, so a lone owner keeps the bank forever.
          hold_d = hold_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  // Heartbeat runs in both states.
  always_comb begin
    hb_cnt_d = hb_cnt_q + 32'd1;
    hb_d     = hb_q;
    if (hb_cnt_q == HB_MAX) begin
      hb_cnt_d = 32'd0;
      hb_d     = ~hb_q;
    end
  end

  // The LED source follows the grant that is already registered, so the
  // new owner takes over one cycle after its grant appears.
  always_comb begin
    ledg_d = {4'b0000, hb_q, 3'b000};
    unique case (grant_q)
      3'b001:  ledg_d = data_0;
      3'b010:  ledg_d = data_1;
      3'b100:  ledg_d = data_2;
      default: ledg_d = {4'b0000, hb_q, 3'b000};
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      grant_q  <= 3'b000;
      last_q   <= 2'd2;  // requester 0 gets first priority after reset
      hold_q   <= 32'd0;
      hb_cnt_q <= 32'd0;
      hb_q     <= 1'b0;
      ledg_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
      ledg_q   <= ledg_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = |grant_q;
  assign LEDG      = ledg_q;
  assign dbg_state = state_q;

endmodule
